// File: rtl/frogger_lane_engine.sv
// frogger_lane_engine: tick prescaler, scrolling obstacle lanes, frog collision and game-state FSM.
module frogger_lane_engine #(
  parameter int NUM_LANES = 8,
  parameter int GRID_W = 20,
  parameter int X_W = 5,
  parameter int FIRST_ROW = 1,
  parameter int GOAL_ROW = 0,
  parameter int TICK_DIV = 2500000,
  parameter int LIVES = 3,
  parameter int HIT_TICKS = 8,
  parameter int MAX_LEVEL = 99,
  parameter logic [NUM_LANES*X_W-1:0] LANE_INIT = '0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Game_Start,
  input  logic [X_W-1:0]           i_Frog_X,
  input  logic [3:0]               i_Frog_Y,
  input  logic [NUM_LANES-1:0]     i_Lane_Dir,
  input  logic [NUM_LANES*4-1:0]   i_Lane_Period,
  output logic [NUM_LANES*X_W-1:0] o_Lane_X,
  output logic                     o_Tick,
  output logic                     o_Collided,
  output logic                     o_Frog_Reset,
  output logic [2:0]               o_Lives,
  output logic [6:0]               o_Level,
  output logic [2:0]               o_State
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, WIN = 3'd3, OVER = 3'd4} state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HIT_TICKS + 1);
  state_t state, state_nxt;
  logic [PW-1:0] presc;
  logic [HW-1:0] hit_cnt;
  logic [X_W-1:0] lane_x [NUM_LANES];
  logic [3:0] lane_cnt [NUM_LANES];
  logic coll, goal, enter_play, hit_done;
  logic [6:0] level_nxt;
  logic [2:0] lives_nxt;
  // Step period shrinks by one tick every four levels, never below one tick.
  function automatic logic [3:0] eff(input logic [3:0] p, input logic [6:0] lv);
    logic [4:0] q;
    q = {1'b0, p == 4'd0 ? 4'd1 : p};
    return q > lv[6:2] ? 4'(q - lv[6:2]) : 4'd1;
  endfunction
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
    assign o_Lane_X[g*X_W +: X_W] = lane_x[g];
  end
  assign o_State = state;
  always_comb begin
    coll = 1'b0;
    for (int l = 0; l < NUM_LANES; l++)
      coll = coll | (lane_x[l] == i_Frog_X && 32'(i_Frog_Y) == 32'(FIRST_ROW + l));
    goal = i_Frog_Y == 4'(GOAL_ROW);
    hit_done = o_Tick && hit_cnt == HW'(HIT_TICKS - 1);
    state_nxt = state;
    level_nxt = o_Level;
    lives_nxt = o_Lives;
    case (state)
      IDLE, OVER: if (i_Game_Start) begin
        state_nxt = PLAY;
        level_nxt = 7'd0;
        lives_nxt = 3'(LIVES);
      end
      PLAY: if (coll) begin
        state_nxt = HIT;
        lives_nxt = o_Lives == 3'd0 ? 3'd0 : o_Lives - 3'd1;
      end else if (goal) state_nxt = WIN;
      HIT: if (hit_done) state_nxt = o_Lives == 3'd0 ? OVER : PLAY;
      WIN: begin
        state_nxt = PLAY;
        level_nxt = o_Level >= 7'(MAX_LEVEL) ? 7'(MAX_LEVEL) : o_Level + 7'd1;
      end
      default: state_nxt = IDLE;
    endcase
    enter_play = state_nxt == PLAY && state != PLAY;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      o_Lives <= '0;
      o_Level <= '0;
      presc <= '0;
      hit_cnt <= '0;
      o_Tick <= 1'b0;
      o_Collided <= 1'b0;
      o_Frog_Reset <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_x[l] <= LANE_INIT[l*X_W +: X_W];
        lane_cnt[l] <= 4'd0;
      end
    end else begin
      presc <= presc == PW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
      o_Tick <= presc == PW'(TICK_DIV - 1);
      state <= state_nxt;
      o_Lives <= lives_nxt;
      o_Level <= level_nxt;
      o_Collided <= state == PLAY && coll;
      o_Frog_Reset <= enter_play;
      hit_cnt <= state != HIT ? '0 : o_Tick ? hit_cnt + 1'b1 : hit_cnt;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (enter_play) begin
          lane_cnt[l] <= eff(i_Lane_Period[l*4 +: 4], level_nxt);
          if (state == IDLE || state == OVER) lane_x[l] <= LANE_INIT[l*X_W +: X_W];
        end else if (state == PLAY && o_Tick) begin
          if (lane_cnt[l] <= 4'd1) begin
            lane_cnt[l] <= eff(i_Lane_Period[l*4 +: 4], o_Level);
            lane_x[l] <= i_Lane_Dir[l]
              ? (lane_x[l] == X_W'(GRID_W - 1) ? '0 : lane_x[l] + 1'b1)
              : (lane_x[l] == '0 ? X_W'(GRID_W - 1) : lane_x[l] - 1'b1);
          end else lane_cnt[l] <= lane_cnt[l] - 4'd1;
        end
      end
    end
  end
endmodule

// File: doc/frogger_lane_engine.md
FROGGER_LANE_ENGINE -- requirements
Module: frogger_lane_engine

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8, meaning the number of obstacle lanes, range 1..14.
REQ-002 SHALL have parameter GRID_W, default 20, meaning the number of playfield columns.
REQ-003 SHALL have parameter X_W, default 5, meaning the column index width, with 2**X_W >= GRID_W.
REQ-004 SHALL have parameter FIRST_ROW, default 1, meaning the grid row of lane 0; lane l occupies row FIRST_ROW+l.
REQ-005 SHALL have parameter GOAL_ROW, default 0, meaning the frog row that counts as a level win.
REQ-006 SHALL have parameter TICK_DIV, default 2500000, meaning i_Clk cycles per game tick.
REQ-007 SHALL have parameter LIVES, default 3, meaning lives granted at game start, range 1..7.
REQ-008 SHALL have parameter HIT_TICKS, default 8, meaning the freeze length after a hit, in ticks.
REQ-009 SHALL have parameter MAX_LEVEL, default 99, meaning the level saturation value.
REQ-010 SHALL have parameter LANE_INIT, default all-zero, meaning packed NUM_LANES*X_W initial lane columns.
REQ-011 SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-012 SHALL have port i_Rst_L, input, 1 bit: reset, synchronous and active-low.
REQ-013 SHALL have port i_Game_Start, input, 1 bit: one-cycle start/restart request.
REQ-014 SHALL have ports i_Frog_X (input, X_W bits) and i_Frog_Y (input, 4 bits): the frog's grid position.
REQ-015 SHALL have port i_Lane_Dir, input, NUM_LANES bits: per-lane direction, 1 = right (+1), 0 = left (-1).
REQ-016 SHALL have port i_Lane_Period, input, NUM_LANES*4 bits: per-lane ticks per step at level 0, where value 0 is treated as 1.
REQ-017 SHALL have port o_Lane_X, output, NUM_LANES*X_W bits: packed current lane columns.
REQ-018 SHALL have port o_Tick, output, 1 bit: one-cycle game-tick pulse.
REQ-019 SHALL have ports o_Collided and o_Frog_Reset, outputs, 1 bit each: one-cycle event pulses.
REQ-020 SHALL have ports o_Lives (3 bits), o_Level (7 bits) and o_State (3 bits), all outputs.

Function
REQ-021 SHALL run the tick prescaler 0..TICK_DIV-1 in every state and pulse o_Tick for one cycle on its wrap.
REQ-022 SHALL implement states IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4, reflected on o_State.
REQ-023 IDLE/OVER: on i_Game_Start SHALL go to PLAY with lives=LIVES, level=0, lanes reloaded from LANE_INIT, and an o_Frog_Reset pulse.
REQ-024 PLAY: per-lane down-counter SHALL decrement on o_Tick; on reaching 1, lane moves one column and counter reloads with eff = max(1, period - o_Level[6:2]).
REQ-025 Wrap: right-moving lane at GRID_W-1 SHALL go to 0; left-moving lane at 0 SHALL go to GRID_W-1.
REQ-026 Lanes SHALL be frozen in every state except PLAY.
REQ-027 Collision SHALL be asserted when any lane l has o_Lane_X[l]==i_Frog_X and FIRST_ROW+l==i_Frog_Y, compared against registered lane positions.
REQ-028 PLAY with collision: SHALL go to HIT, pulse o_Collided in the entry cycle, and decrement lives (floor 0).
REQ-029 PLAY with i_Frog_Y==GOAL_ROW and no collision: SHALL go to WIN; collision takes priority when both occur in the same cycle.
REQ-030 WIN: SHALL increment level saturating at MAX_LEVEL, pulse o_Frog_Reset, and return to PLAY next cycle.
REQ-031 HIT: after HIT_TICKS ticks SHALL go to OVER if lives==0, else to PLAY with an o_Frog_Reset pulse.
REQ-032 i_Game_Start SHALL be ignored in PLAY, HIT and WIN.
REQ-033 Per-lane counters SHALL be reloaded with eff on entry to PLAY.

Reset
REQ-034 While i_Rst_L==0 at a clock edge SHALL set state=IDLE, lives=0, level=0, lanes=LANE_INIT, prescaler and counters=0, and all pulses=0.
REQ-035 Reset asserted mid-game (any state) SHALL take effect on the next edge with no residual pulse.

Verification (TICK_DIV=4, NUM_LANES=2, GRID_W=20, LANE_INIT={5,0}, HIT_TICKS=2)
REQ-036 Reset, then start, with dir={0,1}, period=1 -> o_Tick every 4 cycles; lane0 goes 0,1,2…; lane1 goes 5,4,…,0,19.
REQ-037 Frog at (X=3, Y=1) in lane0's path -> one o_Collided pulse, lives 3->2, state HIT then PLAY after 8 cycles, with o_Frog_Reset.
REQ-038 Three hits -> lives 0 and state OVER; lanes frozen; i_Game_Start -> PLAY, lives=3, level=0.
REQ-039 Frog Y=0 -> WIN, level 0->1, o_Frog_Reset, PLAY next cycle; forced to level 99 then win -> stays 99.
REQ-040 Level 8 with period=3 -> eff=1 (step every tick); collision and goal in the same cycle -> HIT; reset during HIT -> IDLE, lanes=LANE_INIT.
